kronos_mem_arbiter: RTL
=======================

# kronos_mem_arbiter

Two-requester memory-port arbiter for the Kronos core. It shares the single external Wishbone-classic memory port between instruction fetch (IF) and load/store (WB stage). It serialises transfers with data priority bounded by a fairness counter, and forms word-aligned byte lanes from the WB access size.

## Interface
- `FAIR_LIMIT`, default 4: maximum consecutive data grants while an instruction request waits. Legal range is 1..15.
- `clk  in  1` — clock.
- `rst  in  1` — synchronous, active-high reset.
- `instr_addr  in  32` — fetch address. Bits [1:0] are ignored.
- `instr_req  in  1` — fetch request. Held until `instr_ack`.
- `instr_data  out  32` — fetch read data. Valid only with `instr_ack`.
- `instr_ack  out  1` — fetch transfer complete.
- `data_addr  in  32` — load/store byte address.
- `data_size  in  2` — access size, `BYTE`/`HALF`/`WORD`. Equals `funct3[1:0]`.
- `data_wdata  in  32` — store data, LSB-justified.
- `data_wr  in  1` — 1 = store, 0 = load.
- `data_req  in  1` — load/store request. Held until `data_ack`.
- `data_rdata  out  32` — raw, unshifted word. WB performs extraction and sign-extension.
- `data_ack  out  1` — load/store complete.
- `mem_addr  out  32` — word address: {addr[31:2], 2'b00}.
- `mem_wdata  out  32` — lane-shifted store data.
- `mem_mask  out  4` — byte-lane select.
- `mem_wr  out  1` — write enable.
- `mem_stb  out  1` — strobe/cycle.
- `mem_ack  in  1` — transfer complete.
- `mem_rdata  in  32` — read data.

## Operation
- **FSM states:** IDLE, GNT_I, GNT_D.
- **IDLE grant decision** (on the same cycle the requests are seen):
  - Only `instr_req` high → GNT_I.
  - Only `data_req` high → GNT_D.
  - Both high → GNT_D, unless `streak == FAIR_LIMIT`, in which case → GNT_I.
  - Neither high → stay in IDLE.
- **Streak counter** (4 bits):
  - Increments on a data grant made while `instr_req` is high.
  - Clears on any instruction grant.
  - Clears on a data grant made while `instr_req` is low.
  - Saturates at `FAIR_LIMIT`.
- **Grant registers:** on entering a grant state, `mem_addr`, `mem_wdata`, `mem_mask`, `mem_wr` and the granted-source flag are registered. They are held stable until `mem_ack`.
- **Instruction grant:** `mem_mask` = 4'b1111, `mem_wr` = 0.
- **Data grant, with a = `data_addr[1:0]`:**
  - `BYTE`: mask = 4'b0001 << a; wdata = {4{wdata[7:0]}}.
  - `HALF`: mask = 4'b0011 << {a[1], 1'b0}; wdata = {2{wdata[15:0]}}.
  - `WORD`: mask = 4'b1111; wdata unchanged.
  - Size 2'b11 is treated as `WORD`.
  - Misalignment is not checked here; upstream raises the exception and never requests.
- **Acknowledge:**
  - In GNT_x, `mem_stb` = 1.
  - On `mem_ack`: `x_ack` = `mem_ack` combinationally, and `x_data` passes `mem_rdata` through. The FSM then returns to IDLE.
- **Request withdrawn mid-grant (flush):** the transfer runs to `mem_ack`, but the ack is suppressed to the requester. `mem_stb` is never dropped before ack.
- **Non-granted side:** its ack stays 0 at all times.

## Timing
- **Reset values:** state IDLE, streak 0, `mem_stb` 0, `mem_wr` 0, `mem_mask` 0, `mem_addr` 0, `mem_wdata` 0, `instr_ack` 0, `data_ack` 0.
  - `instr_data` and `data_rdata` follow `mem_rdata`; no reset value applies.
- **Latency:**
  - Request high in IDLE at cycle 0 → `mem_stb` high at cycle 1.
  - `mem_ack` at cycle k → requester ack at cycle k (zero-cycle pass-through) → IDLE at k+1.
- **Throughput:** at most one transfer per 2 cycles, because IDLE is always visited. Best-case round trip is 2 cycles when `mem_ack` arrives in the first strobe cycle.
- **Requester rule:** a requester sampling its ack drops or changes `req` before cycle k+1. IDLE at k+1 therefore never sees a stale request.
- **Reset mid-transfer:** the next cycle is IDLE with `mem_stb` = 0. A late `mem_ack` is ignored and no requester ack is issued.
- **Simultaneous requests with `FAIR_LIMIT` = 1:** grants strictly alternate.

## Structure
- Add to the shared `kronos_types` package:
  - an FSM state enum `arb_state_t` = {ARB_IDLE, ARB_GNT_I, ARB_GNT_D};
  - existing `BYTE`/`HALF`/`WORD` constants are reused.
- Sub-module `kronos_lane_align`: purely combinational. Maps {addr[1:0], size, wdata} to {mask, wdata}. It is instantiated once on the data path and is reusable by a future store buffer.

## Test plan
- **Instruction only:** `instr_req`, addr 0x0000_1006; memory acks after 2 strobe cycles with 0xDEADBEEF.
  - `mem_addr` = 0x0000_1004, mask 4'hF.
  - `instr_ack` lands on the ack cycle with `instr_data` = 0xDEADBEEF.
- **Byte/half stores:**
  - SB 0xAB to addr 0x…03 → mask 4'b1000, `mem_wdata` = 0xABABABAB.
  - SH 0x1234 to addr 0x…02 → mask 4'b1100, `mem_wdata` = 0x12341234.
  - SW → mask 4'hF.
- **Contention:** both requests held continuously, `FAIR_LIMIT` = 4, single-cycle ack → grant order D,D,D,D,I,D,D,D,D,I. Each transfer is separated by one IDLE cycle.
- **Flush:** `data_req` dropped two cycles into a GNT_D with delayed ack → strobe held until `mem_ack`, `data_ack` stays 0, next grant proceeds normally.
- **Reset mid-grant:** `rst` asserted during GNT_I → next cycle `mem_stb` = 0, state IDLE, streak 0. A `mem_ack` arriving after reset produces no `instr_ack`.
- **Idle hold:** no requests for 10 cycles → `mem_stb` stays 0 and both acks stay 0.

Source files
------------

// File: rtl/kronos_types.sv
// Shared Kronos type definitions: access-size encodings and the memory
// arbiter state enum.
package kronos_types;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT_I,
        ARB_GNT_D
    } arb_state_t;

endpackage

// File: rtl/kronos_lane_align.sv
// Store lane alignment: turns a byte address offset and access size into a
// Wishbone byte-select mask and replicated store data.
module kronos_lane_align
    import kronos_types::*;
(
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o
);

    // Sub-word data is replicated across the word so whichever lane the mask
    // selects already carries the right bytes; size 2'b11 falls to WORD.
    always_comb begin
        mask_o  = 4'b1111;
        wdata_o = wdata_i;
        case (size_i)
            BYTE: begin
                mask_o  = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            HALF: begin
                mask_o  = 4'b0011 << {addr_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                mask_o  = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/kronos_mem_arbiter.sv
// Shares one Wishbone-classic memory port between instruction fetch and
// load/store, favouring data with a bounded streak so fetch cannot starve.
module kronos_mem_arbiter
    import kronos_types::*;
#(
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_wdata,
    input  logic        data_wr,
    input  logic        data_req,
    output logic [31:0] data_rdata,
    output logic        data_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    output logic        mem_wr,
    output logic        mem_stb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] FairLimit = 4'(FAIR_LIMIT);

    arb_state_t  state_q;
    logic [3:0]  streak_q;
    logic [3:0]  streak_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic        wr_q;
    logic        stb_q;
    logic        srcData_q;
    logic        flush_q;

    logic        grantInstr;
    logic        grantData;
    logic        grantedReq;
    logic [3:0]  laneMask;
    logic [31:0] laneWdata;
    logic        unusedInstrLow;

    assign unusedInstrLow = ^instr_addr[1:0];

    kronos_lane_align uAlign (
        .addr_i  (data_addr[1:0]),
        .size_i  (data_size),
        .wdata_i (data_wdata),
        .mask_o  (laneMask),
        .wdata_o (laneWdata)
    );

    // Data wins unless fetch has already waited through FAIR_LIMIT data grants.
    always_comb begin
        grantData  = data_req && !(instr_req && (streak_q == FairLimit));
        grantInstr = instr_req && !grantData;
        streak_d   = streak_q;
        if (grantInstr) begin
            streak_d = '0;
        end else if (grantData) begin
            if (!instr_req) begin
                streak_d = '0;
            end else if (streak_q != FairLimit) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    assign grantedReq = srcData_q ? data_req : instr_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            streak_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            wr_q      <= 1'b0;
            stb_q     <= 1'b0;
            srcData_q <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    streak_q <= streak_d;
                    flush_q  <= 1'b0;
                    if (grantInstr) begin
                        state_q   <= ARB_GNT_I;
                        stb_q     <= 1'b1;
                        srcData_q <= 1'b0;
                        addr_q    <= {instr_addr[31:2], 2'b00};
                        wdata_q   <= '0;
                        mask_q    <= 4'b1111;
                        wr_q      <= 1'b0;
                    end else if (grantData) begin
                        state_q   <= ARB_GNT_D;
                        stb_q     <= 1'b1;
                        srcData_q <= 1'b1;
                        addr_q    <= {data_addr[31:2], 2'b00};
                        wdata_q   <= laneWdata;
                        mask_q    <= laneMask;
                        wr_q      <= data_wr;
                    end
                end
                ARB_GNT_I, ARB_GNT_D: begin
                    // A withdrawn request still completes on the bus; only
                    // its acknowledge is swallowed.
                    if (mem_ack) begin
                        state_q <= ARB_IDLE;
                        stb_q   <= 1'b0;
                        wr_q    <= 1'b0;
                    end else if (!grantedReq) begin
                        flush_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    stb_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_mask   = mask_q;
    assign mem_wr     = wr_q;
    assign mem_stb    = stb_q;
    assign instr_data = mem_rdata;
    assign data_rdata = mem_rdata;
    assign instr_ack  = stb_q && !srcData_q && mem_ack && instr_req && !flush_q && !rst;
    assign data_ack   = stb_q && srcData_q && mem_ack && data_req && !flush_q && !rst;

endmodule
